// File: rtl/ikaopm_acc_pkg.sv
// Shared constants and the output saturation helper for the OPM sound accumulator.
package ikaopm_acc_pkg;

    localparam logic FMT_FLOAT  = 1'b0;
    localparam logic FMT_LINEAR = 1'b1;
    localparam int   SER_W      = 16;

    // Clamp a signed value to out_w bits (out_w <= SER_W).
    // Returns {clipped, value[SER_W-1:0]}.
    function automatic logic [SER_W:0] sat_fn(input logic signed [31:0] v, input int out_w);
        logic signed [31:0] vmax;
        logic signed [31:0] vmin;
        vmax = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        vmin = -vmax - 32'sd1;
        if (v > vmax)
            sat_fn = {1'b1, vmax[SER_W-1:0]};
        else if (v < vmin)
            sat_fn = {1'b1, vmin[SER_W-1:0]};
        else
            sat_fn = {1'b0, v[SER_W-1:0]};
    endfunction

endpackage

// File: rtl/ikaopm_fp_enc.sv
// Registered serial-word encoder: 16-bit snapshot to float DAC or offset-binary word.
module ikaopm_fp_enc
    import ikaopm_acc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SER_W-1:0] snap,
    input  logic             fmt,
    output logic [SER_W-1:0] word
);

    logic [SER_W-1:0] word_q, word_d;
    logic [2:0]       k;
    logic             run;
    logic [8:0]       mant;

    // Count sign-copies below the sign bit, then pick exponent and mantissa window.
    always_comb begin
        k      = 3'd0;
        run    = 1'b1;
        word_d = '0;
        for (int i = 14; i >= 9; i--) begin
            if (run && (snap[i] == snap[15]))
                k = k + 3'd1;
            else
                run = 1'b0;
        end
        mant = 9'(snap[14:0] >> (3'd6 - k));
        if (fmt == FMT_LINEAR)
            word_d = snap ^ 16'h8000;
        else
            word_d = {3'b000, 3'd7 - k, ~snap[15], mant};
    end

    // Word register; follows the snapshot one enabled cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n)
            word_q <= '0;
        else if (en)
            word_q <= word_d;
    end

    assign word = word_q;

endmodule

// File: rtl/ikaopm_acc_mch.sv
// Multi-channel frame accumulator with saturating snapshot and serial DAC stream.
module ikaopm_acc_mch
    import ikaopm_acc_pkg::*;
#(
    parameter int CH_NUM = 2,
    parameter int SLOTS  = 32,
    parameter int IN_W   = 14,
    parameter int ACC_W  = 18,
    parameter int OUT_W  = 16
)(
    input  logic                    i_EMUCLK,
    input  logic                    i_MRST_n,
    input  logic                    i_phi1_NCEN_n,
    input  logic                    i_FRAME_START,
    input  logic                    i_NOISE_SLOT,
    input  logic                    i_NE,
    input  logic                    i_ACC_SNDADD,
    input  logic [CH_NUM-1:0]       i_ROUTE,
    input  logic [IN_W-1:0]         i_ACC_OPDATA,
    input  logic [IN_W-1:0]         i_ACC_NOISE,
    input  logic                    i_FMT,
    input  logic                    i_CLIP_CLR,
    output logic [CH_NUM*OUT_W-1:0] o_EMU_PO,
    output logic [CH_NUM-1:0]       o_CLIP,
    output logic                    o_SO,
    output logic                    o_SYNC,
    output logic [1:0]              o_CH
);

    // Stream length is capped at the frame length so a stream never spans frames.
    localparam int         BITS     = SER_W * CH_NUM;
    localparam int         STREAM   = (BITS <= SLOTS) ? BITS : SLOTS;
    localparam logic [5:0] CNT_LAST = 6'(STREAM - 1);

    logic en;
    assign en = ~i_phi1_NCEN_n;

    logic [IN_W-1:0]   smp_q, smp_d;
    logic [CH_NUM-1:0] add_q, add_d;
    logic              fs1_q, fs1_d;
    logic              st_q, st_d;
    logic              fmt_q, fmt_d;

    // Stage-1 latch: sample select, per-channel add mask, frame-start delay line, format.
    always_comb begin
        smp_d = (i_NE & i_NOISE_SLOT) ? i_ACC_NOISE : i_ACC_OPDATA;
        add_d = {CH_NUM{i_ACC_SNDADD}} & i_ROUTE;
        fs1_d = i_FRAME_START;
        st_d  = fs1_q;
        fmt_d = fs1_q ? i_FMT : fmt_q;
    end

    // Stage-1 and control registers.
    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            smp_q <= '0;
            add_q <= '0;
            fs1_q <= 1'b0;
            st_q  <= 1'b0;
            fmt_q <= FMT_FLOAT;
        end else if (en) begin
            smp_q <= smp_d;
            add_q <= add_d;
            fs1_q <= fs1_d;
            st_q  <= st_d;
            fmt_q <= fmt_d;
        end
    end

    logic [ACC_W-1:0]   smp_ext;
    logic [BITS-1:0]    word_bus;
    assign smp_ext = ACC_W'($signed(smp_q));

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
        logic [ACC_W-1:0] acc_q, acc_d;
        logic [ACC_W-1:0] addend;
        logic [OUT_W-1:0] snap_q, snap_d;
        logic             clip_q, clip_d;
        logic [SER_W:0]   sat_r;

        // Accumulate, snapshot the old sum on frame start, track sticky clip.
        always_comb begin
            sat_r  = sat_fn(32'($signed(acc_q)), OUT_W);
            addend = add_q[gi] ? smp_ext : '0;
            acc_d  = fs1_q ? addend : acc_q + addend;
            snap_d = fs1_q ? sat_r[OUT_W-1:0] : snap_q;
            clip_d = clip_q;
            if (i_CLIP_CLR)
                clip_d = 1'b0;
            if (fs1_q && sat_r[SER_W])
                clip_d = 1'b1;
        end

        // Per-channel state.
        always_ff @(posedge i_EMUCLK) begin
            if (!i_MRST_n) begin
                acc_q  <= '0;
                snap_q <= '0;
                clip_q <= 1'b0;
            end else if (en) begin
                acc_q  <= acc_d;
                snap_q <= snap_d;
                clip_q <= clip_d;
            end
        end

        assign o_EMU_PO[gi*OUT_W +: OUT_W] = snap_q;
        assign o_CLIP[gi]                  = clip_q;

        ikaopm_fp_enc u_enc (
            .clk   (i_EMUCLK),
            .rst_n (i_MRST_n),
            .en    (en),
            .snap  (SER_W'($signed(snap_q))),
            .fmt   (fmt_q),
            .word  (word_bus[gi*SER_W +: SER_W])
        );
    end

    logic [5:0]  cnt_q, cnt_d;
    logic        act_q, act_d;
    logic        so_q, so_d;
    logic        sync_q, sync_d;
    logic [1:0]  ch_q, ch_d;
    logic [63:0] word_pad;
    assign word_pad = 64'(word_bus);

    // Serial bit counter and output mux; a new snapshot restarts the stream.
    always_comb begin
        cnt_d  = cnt_q;
        act_d  = act_q;
        so_d   = act_q & word_pad[cnt_q];
        sync_d = act_q & (cnt_q == 6'd0);
        ch_d   = act_q ? cnt_q[5:4] : 2'd0;
        if (act_q) begin
            if (cnt_q == CNT_LAST)
                act_d = 1'b0;
            else
                cnt_d = cnt_q + 6'd1;
        end
        if (st_q) begin
            cnt_d = 6'd0;
            act_d = 1'b1;
        end
    end

    // Serial output registers.
    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            cnt_q  <= '0;
            act_q  <= 1'b0;
            so_q   <= 1'b0;
            sync_q <= 1'b0;
            ch_q   <= 2'd0;
        end else if (en) begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            so_q   <= so_d;
            sync_q <= sync_d;
            ch_q   <= ch_d;
        end
    end

    assign o_SO   = so_q;
    assign o_SYNC = sync_q;
    assign o_CH   = ch_q;

endmodule

// File: tb/tb_ikaopm_acc_mch.sv
// Directed bench for ikaopm_acc_mch (2 channels, 16-bit output).
module tb_ikaopm_acc_mch;

    logic        clk;
    logic        i_MRST_n;
    logic        i_phi1_NCEN_n;
    logic        i_FRAME_START;
    logic        i_NOISE_SLOT;
    logic        i_NE;
    logic        i_ACC_SNDADD;
    logic [1:0]  i_ROUTE;
    logic [13:0] i_ACC_OPDATA;
    logic [13:0] i_ACC_NOISE;
    logic        i_FMT;
    logic        i_CLIP_CLR;
    logic [31:0] o_EMU_PO;
    logic [1:0]  o_CLIP;
    logic        o_SO;
    logic        o_SYNC;
    logic [1:0]  o_CH;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] s;
    logic        sy0, sy1;
    logic [1:0]  c15, c16;

    ikaopm_acc_mch #(
        .CH_NUM(2), .SLOTS(32), .IN_W(14), .ACC_W(18), .OUT_W(16)
    ) dut (
        .i_EMUCLK      (clk),
        .i_MRST_n      (i_MRST_n),
        .i_phi1_NCEN_n (i_phi1_NCEN_n),
        .i_FRAME_START (i_FRAME_START),
        .i_NOISE_SLOT  (i_NOISE_SLOT),
        .i_NE          (i_NE),
        .i_ACC_SNDADD  (i_ACC_SNDADD),
        .i_ROUTE       (i_ROUTE),
        .i_ACC_OPDATA  (i_ACC_OPDATA),
        .i_ACC_NOISE   (i_ACC_NOISE),
        .i_FMT         (i_FMT),
        .i_CLIP_CLR    (i_CLIP_CLR),
        .o_EMU_PO      (o_EMU_PO),
        .o_CLIP        (o_CLIP),
        .o_SO          (o_SO),
        .o_SYNC        (o_SYNC),
        .o_CH          (o_CH)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle();
        i_FRAME_START = 1'b0;
        i_NOISE_SLOT  = 1'b0;
        i_NE          = 1'b0;
        i_ACC_SNDADD  = 1'b0;
        i_ROUTE       = 2'b00;
        i_ACC_OPDATA  = '0;
        i_ACC_NOISE   = '0;
        i_CLIP_CLR    = 1'b0;
    endtask

    task automatic put(input logic [13:0] d, input logic [1:0] r);
        i_ACC_SNDADD = 1'b1;
        i_ACC_OPDATA = d;
        i_ROUTE      = r;
        tick();
        idle();
    endtask

    task automatic fstart();
        i_FRAME_START = 1'b1;
        tick();
        idle();
    endtask

    // Capture 32 serial bits, one per enabled cycle, starting with the visible bit.
    task automatic grab(output logic [31:0] w, output logic y0, output logic y1,
                        output logic [1:0] h15, output logic [1:0] h16);
        w = '0; y0 = 1'b0; y1 = 1'b0; h15 = 2'd0; h16 = 2'd0;
        for (int i = 0; i < 32; i++) begin
            w[i] = o_SO;
            if (i == 0)  y0  = o_SYNC;
            if (i == 1)  y1  = o_SYNC;
            if (i == 15) h15 = o_CH;
            if (i == 16) h16 = o_CH;
            tick();
        end
        $display("stream word=0x%08h sync0=%0b sync1=%0b ch15=%0d ch16=%0d", w, y0, y1, h15, h16);
    endtask

    initial begin
        i_MRST_n      = 1'b0;
        i_phi1_NCEN_n = 1'b0;
        i_FMT         = 1'b0;
        idle();

        // Reset state
        tick(); tick(); tick();
        chk("rst_po",   o_EMU_PO, 64'h0);
        chk("rst_clip", o_CLIP,   64'h0);
        chk("rst_so",   o_SO,     64'h0);
        chk("rst_sync", o_SYNC,   64'h0);
        chk("rst_ch",   o_CH,     64'h0);
        i_MRST_n = 1'b1;
        tick();

        // Frame 1: float, ch0 = 3 x 0x0100
        fstart();
        put(14'h0100, 2'b01);
        put(14'h0100, 2'b01);
        put(14'h0100, 2'b01);
        fstart();
        tick();
        chk("f1_po",   o_EMU_PO, 64'h0000_0300);
        chk("f1_clip", o_CLIP,   64'h0);
        tick(); tick();
        grab(s, sy0, sy1, c15, c16);
        chk("f1_stream", s,   64'h0600_0B80);
        chk("f1_sync0",  sy0, 64'h1);
        chk("f1_sync1",  sy1, 64'h0);
        chk("f1_ch15",   c15, 64'h0);
        chk("f1_ch16",   c16, 64'h1);
        chk("f1_so_end",   o_SO,   64'h0);
        chk("f1_sync_end", o_SYNC, 64'h0);

        // Frame 2: linear, ch1 overflows, clip clear in the snapshot cycle loses
        i_FMT = 1'b1;
        for (int i = 0; i < 8; i++) put(14'h1FFF, 2'b10);
        fstart();
        i_CLIP_CLR = 1'b1;
        tick();
        i_CLIP_CLR = 1'b0;
        chk("f2_po",   o_EMU_PO, 64'h7FFF_0000);
        chk("f2_clip", o_CLIP,   64'h2);
        tick(); tick();
        grab(s, sy0, sy1, c15, c16);
        chk("f2_stream", s, 64'hFFFF_8000);

        // Frame 3: float, noise slot on ch0, masked and invalid adds ignored
        i_FMT = 1'b0;
        i_CLIP_CLR = 1'b1;
        tick();
        i_CLIP_CLR = 1'b0;
        chk("clip_clr", o_CLIP, 64'h0);
        i_NE = 1'b1; i_NOISE_SLOT = 1'b1; i_ACC_NOISE = 14'h2000;
        put(14'h0123, 2'b01);
        put(14'h0555, 2'b00);
        i_ACC_OPDATA = 14'h0777; i_ROUTE = 2'b11;
        tick();
        idle();
        fstart();
        tick();
        chk("f3_po",   o_EMU_PO, 64'h0000_E000);
        chk("f3_clip", o_CLIP,   64'h0);
        tick(); tick();
        grab(s, sy0, sy1, c15, c16);
        chk("f3_stream", s, 64'h0600_1400);

        // Frame 4: linear, ch0 = -1; ch1 boundary (last slot old, slot 0 new)
        i_FMT = 1'b1;
        put(14'h3FFF, 2'b01);
        put(14'h0010, 2'b10);
        i_FRAME_START = 1'b1; i_ACC_SNDADD = 1'b1; i_ACC_OPDATA = 14'h0020; i_ROUTE = 2'b10;
        tick();
        idle();
        tick();
        chk("f4_po", o_EMU_PO, 64'h0010_FFFF);
        tick(); tick();
        grab(s, sy0, sy1, c15, c16);
        chk("f4_stream", s,   64'h8010_7FFF);
        chk("f4_sync0",  sy0, 64'h1);
        chk("f4_ch16",   c16, 64'h1);

        // Frame 5: carry-over of slot-0 sample, then restart mid-stream
        fstart();
        tick();
        chk("f5_po", o_EMU_PO, 64'h0020_0000);
        tick(); tick();
        chk("f5_sync0", o_SYNC, 64'h1);
        put(14'h0100, 2'b01);
        tick();
        fstart();
        tick();
        chk("f6_po", o_EMU_PO, 64'h0000_0100);
        tick(); tick();
        chk("restart_sync", o_SYNC, 64'h1);
        chk("restart_ch",   o_CH,   64'h0);

        // Clock enable high: nothing moves
        i_phi1_NCEN_n = 1'b1;
        i_FRAME_START = 1'b1; i_ACC_SNDADD = 1'b1; i_ROUTE = 2'b11;
        i_ACC_OPDATA = 14'h1234; i_CLIP_CLR = 1'b1; i_FMT = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("hold_sync", o_SYNC,   64'h1);
        chk("hold_so",   o_SO,     64'h0);
        chk("hold_ch",   o_CH,     64'h0);
        chk("hold_po",   o_EMU_PO, 64'h0000_0100);
        i_phi1_NCEN_n = 1'b0;
        i_FMT = 1'b1;
        idle();
        tick();
        chk("f6_sync1", o_SYNC, 64'h0);
        put(14'h0100, 2'b01);
        for (int i = 0; i < 6; i++) tick();
        chk("f6_bit8", o_SO, 64'h1);
        chk("f6_ch8",  o_CH, 64'h0);

        // Reset mid-stream
        i_MRST_n = 1'b0;
        tick();
        chk("mrst_po",   o_EMU_PO, 64'h0);
        chk("mrst_clip", o_CLIP,   64'h0);
        chk("mrst_so",   o_SO,     64'h0);
        chk("mrst_sync", o_SYNC,   64'h0);
        chk("mrst_ch",   o_CH,     64'h0);
        i_MRST_n = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_so", o_SO, 64'h0);
        fstart();
        tick();
        chk("post_rst_po", o_EMU_PO, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
